// File: rtl/alu_input_sequencer_pkg.sv
// Shared types for the ALU board-harness input side: operand/opcode words and sequencer states.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package alu_input_sequencer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } seq_state_t;

    // SW[17] selects zero- or sign-extension of the 17-bit switch field.
    function automatic word_t capture_operand(input logic [17:0] sw);
        word_t w;
        if (sw[17]) begin
            w = {{15{sw[16]}}, sw[16:0]};
        end else begin
            w = {15'b0, sw[16:0]};
        end
        return w;
    endfunction

    // One-hot LED pattern for a state: bit index equals the state encoding.
    function automatic logic [3:0] state_leds(input seq_state_t s);
        logic [3:0] l;
        l = 4'b0001 << s;
        return l;
    endfunction

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Operand/opcode bundle between the input sequencer and the ALU under test.
// Latency: none (wires only).
// Backpressure: none; operands_valid marks when the bundle is complete.
interface alu_input_sequencer_if;
    import alu_input_sequencer_pkg::*;

    word_t  port_a;
    word_t  port_b;
    aluop_t alu_op;
    logic   operands_valid;

    modport master (
        output port_a,
        output port_b,
        output alu_op,
        output operands_valid
    );

    modport slave (
        input port_a,
        input port_b,
        input alu_op,
        input operands_valid
    );

endinterface

// File: rtl/alu_input_sequencer_key_debounce.sv
// Synchronise and debounce one active-low pushbutton into a single-cycle press pulse.
// Latency: raw fall to press = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
// Backpressure: none; a key held through reset is ignored until released once.
module key_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CW-1:0]          cnt_q;
    logic                   armed_q;
    logic                   key_s;
    logic                   flushed;

    assign key_s   = sync_q[SYNC_STAGES-1];
    assign flushed = fill_q[SYNC_STAGES-1];

    // Synchroniser chain plus a fill marker telling when its output reflects the real pin.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '1;
            fill_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(key_n);
            fill_q <= (fill_q << 1) | SYNC_STAGES'(1);
        end
    end

    // Arm only after a genuine released level is seen, so a key held across reset is swallowed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_q | (flushed & key_s);
        end
    end

    // Accept a level change only after it has held for DEBOUNCE_CYCLES; pulse on accepted press.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            stable <= 1'b1;
            press  <= 1'b0;
        end else if (key_s == stable) begin
            cnt_q <= '0;
            press <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            stable <= key_s;
            press  <= armed_q & ~key_s;
        end else begin
            cnt_q <= cnt_q + CW'(1);
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_input_sequencer.sv
// Step the user through loading ALU operand A, operand B and opcode from DE2 keys and switches.
// Latency: key fall to press SYNC_STAGES+DEBOUNCE_CYCLES; registers/state update one cycle later.
// Backpressure: none; simultaneous presses resolve KEY3 > KEY0 > KEY1 > KEY2, losers dropped.
module alu_input_sequencer
    import alu_input_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            KEY,
    input  logic [17:0]           SW,
    alu_input_sequencer_if.master alu_if,
    output logic [3:0]            LEDR
);

    logic [SYNC_STAGES-1:0][17:0] sw_q;
    logic [17:0]                  sw_s;
    logic [3:0]                   press;
    logic [3:0]                   key_stable;
    logic                         unused_stable;

    seq_state_t state_q, state_nxt;
    word_t      a_q, a_nxt, b_q, b_nxt;
    aluop_t     op_q, op_nxt;
    logic       valid_q;

    assign sw_s          = sw_q[SYNC_STAGES-1];
    assign unused_stable = &key_stable;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK   (CLK),
            .nRST  (nRST),
            .key_n (KEY[k]),
            .stable(key_stable[k]),
            .press (press[k])
        );
    end

    // Switches are only synchronised; they are sampled solely on a debounced key event.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_q <= '0;
        end else begin
            sw_q[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_q[i] <= sw_q[i-1];
            end
        end
    end

    // Next state and register values; only the highest-priority press this cycle acts.
    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        if (press[3]) begin
            state_nxt = LOAD_A;
            a_nxt     = '0;
            b_nxt     = '0;
            op_nxt    = '0;
        end else if (press[0]) begin
            case (state_q)
                LOAD_A: begin
                    a_nxt     = capture_operand(sw_s);
                    state_nxt = LOAD_B;
                end
                LOAD_B: begin
                    b_nxt     = capture_operand(sw_s);
                    state_nxt = LOAD_OP;
                end
                LOAD_OP: begin
                    op_nxt    = sw_s[3:0];
                    state_nxt = SHOW;
                end
                default: state_nxt = LOAD_A;
            endcase
        end else if (press[1]) begin
            case (state_q)
                LOAD_B:  state_nxt = LOAD_A;
                LOAD_OP: state_nxt = LOAD_B;
                SHOW:    state_nxt = LOAD_OP;
                default: state_nxt = LOAD_A;
            endcase
        end else if (press[2] && (state_q == SHOW)) begin
            a_nxt = b_q;
            b_nxt = a_q;
        end
    end

    // State, operand registers and the state-derived outputs, all updated together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            LEDR    <= 4'b0001;
        end else begin
            state_q <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            op_q    <= op_nxt;
            valid_q <= (state_nxt == SHOW);
            LEDR    <= state_leds(state_nxt);
        end
    end

    assign alu_if.port_a         = a_q;
    assign alu_if.port_b         = b_q;
    assign alu_if.alu_op         = op_q;
    assign alu_if.operands_valid = valid_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for the ALU input sequencer with short debounce.
// Latency: drives and samples 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_alu_input_sequencer;
    import alu_input_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [3:0]  LEDR;
    int          checks = 0;
    int          errors = 0;

    alu_input_sequencer_if alu_bus ();

    alu_input_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .KEY   (KEY),
        .SW    (SW),
        .alu_if(alu_bus),
        .LEDR  (LEDR)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tap(input int idx);
        KEY[idx] = 1'b0;
        step(9);
        KEY[idx] = 1'b1;
        step(9);
    endtask

    task automatic test_reset;
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL reset_ledr: got %b expected %b", LEDR, 4'b0001); end
        checks++; if (alu_bus.port_a !== 32'h0) begin errors++; $display("FAIL reset_port_a: got %h expected 0", alu_bus.port_a); end
        checks++; if (alu_bus.port_b !== 32'h0) begin errors++; $display("FAIL reset_port_b: got %h expected 0", alu_bus.port_b); end
        checks++; if (alu_bus.alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_op: got %h expected 0", alu_bus.alu_op); end
        checks++; if (alu_bus.operands_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", alu_bus.operands_valid); end
    endtask

    task automatic test_glitch;
        KEY[0] = 1'b0;
        step(3);
        KEY[0] = 1'b1;
        step(12);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL glitch_ledr: got %b expected %b", LEDR, 4'b0001); end
    endtask

    task automatic test_back_noop;
        tap(1);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL back_in_load_a: got %b expected %b", LEDR, 4'b0001); end
    endtask

    task automatic test_sequence;
        int n;
        bit found;
        SW = 18'h00005;
        step(3);
        KEY[0] = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            step(1);
            if (LEDR !== 4'b0001) begin
                n = i;
                found = 1'b1;
            end
        end
        // Press pulse follows 6 edges after the fall; the state change is seen one edge later.
        checks++; if (n !== 7) begin errors++; $display("FAIL press_latency: state changed after %0d edges expected 7", n); end
        step(2);
        KEY[0] = 1'b1;
        step(9);
        checks++; if (alu_bus.port_a !== 32'h00000005) begin errors++; $display("FAIL load_a: got %h expected 00000005", alu_bus.port_a); end
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL ledr_load_b: got %b expected 0010", LEDR); end
        SW = 18'h00003;
        tap(0);
        checks++; if (alu_bus.port_b !== 32'h00000003) begin errors++; $display("FAIL load_b: got %h expected 00000003", alu_bus.port_b); end
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL ledr_load_op: got %b expected 0100", LEDR); end
        SW = 18'h00002;
        tap(0);
        checks++; if (alu_bus.alu_op !== 4'h2) begin errors++; $display("FAIL load_op: got %h expected 2", alu_bus.alu_op); end
        checks++; if (alu_bus.operands_valid !== 1'b1) begin errors++; $display("FAIL show_valid: got %b expected 1", alu_bus.operands_valid); end
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL ledr_show: got %b expected 1000", LEDR); end
    endtask

    task automatic test_swap_back;
        tap(2);
        checks++; if (alu_bus.port_a !== 32'h3) begin errors++; $display("FAIL swap_a: got %h expected 00000003", alu_bus.port_a); end
        checks++; if (alu_bus.port_b !== 32'h5) begin errors++; $display("FAIL swap_b: got %h expected 00000005", alu_bus.port_b); end
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL swap_state: got %b expected 1000", LEDR); end
        tap(1);
        checks++; if (LEDR !== 4'b0100) begin errors++; $display("FAIL back_state: got %b expected 0100", LEDR); end
        checks++; if (alu_bus.operands_valid !== 1'b0) begin errors++; $display("FAIL back_valid: got %b expected 0", alu_bus.operands_valid); end
        checks++; if (alu_bus.port_a !== 32'h3 || alu_bus.port_b !== 32'h5 || alu_bus.alu_op !== 4'h2) begin
            errors++; $display("FAIL back_regs: got a=%h b=%h op=%h expected a=3 b=5 op=2", alu_bus.port_a, alu_bus.port_b, alu_bus.alu_op);
        end
    endtask

    task automatic test_hold;
        SW = 18'h00002;
        KEY[0] = 1'b0;
        step(30);
        checks++; if (LEDR !== 4'b1000) begin errors++; $display("FAIL hold_single_event: got %b expected 1000", LEDR); end
        KEY[0] = 1'b1;
        step(9);
        tap(0);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL show_to_load_a: got %b expected 0001", LEDR); end
        checks++; if (alu_bus.port_a !== 32'h3 || alu_bus.port_b !== 32'h5) begin
            errors++; $display("FAIL regs_held: got a=%h b=%h expected a=3 b=5", alu_bus.port_a, alu_bus.port_b);
        end
    endtask

    task automatic test_sign_ext;
        SW = 18'h3FFFF;
        tap(0);
        checks++; if (alu_bus.port_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL sign_ext: got %h expected ffffffff", alu_bus.port_a); end
        tap(1);
        SW = 18'h1FFFF;
        tap(0);
        checks++; if (alu_bus.port_a !== 32'h0001FFFF) begin errors++; $display("FAIL zero_ext: got %h expected 0001ffff", alu_bus.port_a); end
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL ext_state: got %b expected 0010", LEDR); end
    endtask

    task automatic test_simultaneous;
        SW = 18'h00007;
        KEY[0] = 1'b0;
        KEY[3] = 1'b0;
        step(9);
        KEY[0] = 1'b1;
        KEY[3] = 1'b1;
        step(9);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL clear_state: got %b expected 0001", LEDR); end
        checks++; if (alu_bus.port_a !== 32'h0 || alu_bus.port_b !== 32'h0 || alu_bus.alu_op !== 4'h0) begin
            errors++; $display("FAIL clear_regs: got a=%h b=%h op=%h expected all 0", alu_bus.port_a, alu_bus.port_b, alu_bus.alu_op);
        end
    endtask

    task automatic test_reset_midway;
        SW = 18'h00009;
        tap(0);
        checks++; if (alu_bus.port_a !== 32'h9) begin errors++; $display("FAIL pre_reset_a: got %h expected 00000009", alu_bus.port_a); end
        KEY[0] = 1'b0;
        step(5);
        nRST = 1'b0;
        #1;
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL async_reset_ledr: got %b expected 0001", LEDR); end
        checks++; if (alu_bus.port_a !== 32'h0) begin errors++; $display("FAIL async_reset_a: got %h expected 0", alu_bus.port_a); end
        step(2);
        nRST = 1'b1;
        step(20);
        checks++; if (LEDR !== 4'b0001) begin errors++; $display("FAIL held_through_reset: got %b expected 0001", LEDR); end
        KEY[0] = 1'b1;
        step(9);
        SW = 18'h00011;
        tap(0);
        checks++; if (LEDR !== 4'b0010) begin errors++; $display("FAIL repress_state: got %b expected 0010", LEDR); end
        checks++; if (alu_bus.port_a !== 32'h11) begin errors++; $display("FAIL repress_a: got %h expected 00000011", alu_bus.port_a); end
    endtask

    initial begin
        nRST = 1'b0;
        KEY  = 4'hF;
        SW   = 18'h0;
        step(3);
        test_reset;
        nRST = 1'b1;
        step(6);
        test_glitch;
        test_back_noop;
        test_sequence;
        test_swap_back;
        test_hold;
        test_sign_ext;
        test_simultaneous;
        test_reset_midway;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
Input side of the board-level ALU test harness. Turns raw DE2 pushbuttons and slide switches into clean, registered ALU operands and opcode, driving alu_if port_a, port_b and alu_op. Keys are synchronised and debounced into single-cycle press events. A small FSM steps the user through loading A, B and the opcode. This replaces level-sensitive latching of switches with a fully clocked path.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key change is accepted (10 ms at 50 MHz); 1 is legal for simulation
SYNC_STAGES, 2, flip-flop stages on every raw KEY/SW bit

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
KEY  input  4  raw pushbuttons, active-low (0 = pressed)
SW  input  18  raw slide switches
port_a  output  32  operand A (word_t)
port_b  output  32  operand B (word_t)
alu_op  output  4  opcode (aluop_t)
operands_valid  output  1  high only in SHOW
LEDR  output  4  one-hot state: [0] LOAD_A, [1] LOAD_B, [2] LOAD_OP, [3] SHOW

Behaviour:
- One clock domain, CLK. Reset is asynchronous and active-low on nRST. Every flop clears on nRST low, independent of CLK.
- Reset values:
  - port_a, port_b, alu_op = 0
  - operands_valid = 0
  - state = LOAD_A, LEDR = 4'b0001
  - KEY synchroniser and debounced-stable flops = 1 (released)
  - SW synchroniser flops = 0
  - debounce counters = 0
- Synchroniser: SYNC_STAGES flops per bit on KEY and SW. SW is not debounced.
- Debounce, one per key:
  - counter width $clog2(DEBOUNCE_CYCLES+1)
  - counter clears in any cycle where the synchronised key equals the stable value
  - otherwise it increments; on reaching DEBOUNCE_CYCLES, stable takes the synchronised value and the counter clears
  - press[i] is a one-cycle pulse on a stable 1->0 transition; release generates no event
  - a glitch shorter than DEBOUNCE_CYCLES produces no pulse
- Latency:
  - raw KEY fall to press pulse = SYNC_STAGES + DEBOUNCE_CYCLES cycles
  - operand and state update visible on the cycle after the pulse
- Operand capture: capture uses the synchronised SW value in the pulse cycle.
  - SW[17] = 0: operand = {15'b0, SW[16:0]}
  - SW[17] = 1: operand = sign-extension of SW[16:0]
- Key roles: KEY0 = commit, KEY1 = back, KEY2 = swap, KEY3 = clear.
- Event priority within one cycle: KEY3 > KEY0 > KEY1 > KEY2. Only the highest-priority press acts; the others are dropped, not queued.
- FSM transitions on KEY0 press:
  - LOAD_A -> LOAD_B: port_a <= captured operand
  - LOAD_B -> LOAD_OP: port_b <= captured operand
  - LOAD_OP -> SHOW: alu_op <= SW[3:0]
  - SHOW -> LOAD_A: registers are held until overwritten
- KEY1 press: step back one state (LOAD_B -> LOAD_A, LOAD_OP -> LOAD_B, SHOW -> LOAD_OP) with no register change. In LOAD_A it is a no-op.
- KEY2 press: in SHOW only, port_a and port_b exchange in one cycle. Ignored in all other states.
- KEY3 press: from any state, go to LOAD_A and clear port_a, port_b and alu_op to 0.
- operands_valid = (state == SHOW), registered and aligned with LEDR[3].
- Holding a key produces exactly one press event. A new event requires release, then a fresh press.
- nRST asserted mid-debounce or mid-sequence: everything returns to reset values immediately. A key still held at release of reset produces no press until it is released and pressed again.

Decomposition:
- cpu_types_pkg (existing) supplies word_t and aluop_t.
- Add to the package: seq_state_t enum {LOAD_A, LOAD_B, LOAD_OP, SHOW}, 2 bits.
- Sub-module key_debounce: one key, with parameters SYNC_STAGES and DEBOUNCE_CYCLES. Ports CLK, nRST, key_n, stable, press. Instantiate it 4 times.
- The SW synchroniser stays inline.
- The top-level alu_fpga instantiates alu_input_sequencer and feeds alu_if from it.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Hold KEY0 low for 3 cycles, then release. -> No press event, state stays LOAD_A, LEDR=0001.
- Run the full sequence:
  - SW=0x00005 with KEY0 press -> port_a = 0x00000005
  - SW=0x00003 with KEY0 press -> port_b = 0x00000003
  - SW[3:0]=4'h2 with KEY0 press -> alu_op = 2, operands_valid = 1, LEDR = 1000
  - the press pulse arrives exactly 6 cycles after the KEY0 fall
- SW = 18'h3FFFF with SW[17]=1 in LOAD_A, KEY0 press. -> port_a = 0xFFFFFFFF. With SW[17]=0 -> port_a = 0x0001FFFF.
- In SHOW with port_a = 5 and port_b = 3, press KEY2. -> port_a = 3, port_b = 5, state stays SHOW. Then press KEY1. -> state = LOAD_OP, operands_valid = 0, registers unchanged.
- Press KEY0 and KEY3 in the same debounce window so both pulses land in the same cycle, in state LOAD_B. -> state = LOAD_A, all operands and alu_op = 0; the KEY0 capture is not performed.
- Assert nRST while a KEY0 debounce count is at 3. -> Outputs return to reset values immediately. After reset is released, a still-held KEY0 causes no event until it is released and pressed again.
